// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg: shared definitions for the clock period meter.
//   - meter_state_e : measurement FSM states
//   - CNT_WIDTH_DEF : default counter / result width
//   - TIMEOUT_DEF   : default timeout in system clock cycles
package clk_meter_pkg;

  localparam int CNT_WIDTH_DEF = 32;
  localparam int TIMEOUT_DEF   = 1000000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MEAS_HI = 3'd2,
    MEAS_LO = 3'd3,
    DONE    = 3'd4
  } meter_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer for an asynchronous input followed
// by single-cycle rise/fall pulse generation in the clk domain.
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset (all flops to 0)
//   sig_i   asynchronous input
//   rise_o  one-cycle pulse on a synchronized 0->1 transition
//   fall_o  one-cycle pulse on a synchronized 1->0 transition
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      s_d_q  <= s;
    end
  end

  assign rise_o = s & ~s_d_q;
  assign fall_o = ~s & s_d_q;

endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow asynchronous
// signal in units of clk, reporting each result over a valid/ready pair.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   sig_in            monitored signal (asynchronous to clk)
//   start             one-cycle pulse, arms a measurement from IDLE
//   cont              continuous mode: each closing rise opens the next period
//   res_valid/ready   result handshake
//   period, high_time last result in clk cycles
//   busy              FSM not in IDLE
//   timeout, overrun  sticky status flags (cleared by start)
// Optional feature macro CLK_PERIOD_METER_MINMAX_EN adds period_min and
// period_max, tracking the extremes of all results since the last start.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_in,
  input  logic                 start,
  input  logic                 cont,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 busy,
  output logic                 timeout,
`ifdef CLK_PERIOD_METER_MINMAX_EN
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] period_min,
  output logic [CNT_WIDTH-1:0] period_max
`else
  output logic                 overrun
`endif
);

  localparam logic [CNT_WIDTH-1:0] TMO_CNT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  meter_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 res_valid_q, res_valid_d;
  logic                 timeout_q, timeout_d;
  logic                 overrun_q, overrun_d;
`ifdef CLK_PERIOD_METER_MINMAX_EN
  logic [CNT_WIDTH-1:0] pmin_q, pmin_d;
  logic [CNT_WIDTH-1:0] pmax_q, pmax_d;
`endif

  logic rise, fall, tmo_hit, load;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (sig_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign tmo_hit = (cnt_q == TMO_CNT);
  // A result is produced by the closing rise of a measured period.
  assign load    = (state_q == MEAS_LO) && rise;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_cnt_q    <= '0;
      period_q    <= '0;
      high_q      <= '0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef CLK_PERIOD_METER_MINMAX_EN
      pmin_q      <= '0;
      pmax_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      res_valid_q <= res_valid_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
`ifdef CLK_PERIOD_METER_MINMAX_EN
      pmin_q      <= pmin_d;
      pmax_q      <= pmax_d;
`endif
    end
  end

  // Next-state logic; edges take priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM:     if (rise) state_d = MEAS_HI;
               else if (tmo_hit) state_d = IDLE;
      MEAS_HI: if (fall) state_d = MEAS_LO;
               else if (tmo_hit) state_d = IDLE;
      MEAS_LO: if (rise) state_d = cont ? MEAS_HI : DONE;
               else if (tmo_hit) state_d = IDLE;
      DONE:    if (res_valid_q && res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, result registers and flags
  always_comb begin
    cnt_d       = cnt_q;
    hi_cnt_d    = hi_cnt_q;
    period_d    = period_q;
    high_d      = high_q;
    res_valid_d = res_valid_q;
    timeout_d   = timeout_q;
    overrun_d   = overrun_q;
`ifdef CLK_PERIOD_METER_MINMAX_EN
    pmin_d      = pmin_q;
    pmax_d      = pmax_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d     = '0;
          timeout_d = 1'b0;
          overrun_d = 1'b0;
`ifdef CLK_PERIOD_METER_MINMAX_EN
          pmin_d    = '1;
          pmax_d    = '0;
`endif
        end
      end
      ARM: begin
        if (rise)         cnt_d     = ONE;
        else if (tmo_hit) timeout_d = 1'b1;
        else              cnt_d     = cnt_q + ONE;
      end
      MEAS_HI: begin
        cnt_d = cnt_q + ONE;
        if (fall)         hi_cnt_d  = cnt_q;
        else if (tmo_hit) timeout_d = 1'b1;
      end
      MEAS_LO: begin
        if (rise)         cnt_d     = ONE;
        else if (tmo_hit) timeout_d = 1'b1;
        else              cnt_d     = cnt_q + ONE;
      end
      default: ;
    endcase

    // Result handshake: a load wins over a coincident accept, so
    // res_valid only drops on an accept cycle without new data.
    if (load) begin
      period_d    = cnt_q;
      high_d      = hi_cnt_q;
      res_valid_d = 1'b1;
      if (res_valid_q && !res_ready) overrun_d = 1'b1;
`ifdef CLK_PERIOD_METER_MINMAX_EN
      if (cnt_q < pmin_q) pmin_d = cnt_q;
      if (cnt_q > pmax_q) pmax_d = cnt_q;
`endif
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    res_valid  = res_valid_q;
    period     = period_q;
    high_time  = high_q;
    busy       = (state_q != IDLE);
    timeout    = timeout_q;
    overrun    = overrun_q;
`ifdef CLK_PERIOD_METER_MINMAX_EN
    period_min = pmin_q;
    period_max = pmax_q;
`endif
  end

endmodule
